// File: rtl/ac_motor_gate_driver_pkg.sv
// ac_motor_pkg: space-vector constants, sector mapping and leg state encoding
package ac_motor_pkg;

    localparam logic [2:0] V0 = 3'b000;
    localparam logic [2:0] V1 = 3'b100;
    localparam logic [2:0] V2 = 3'b110;
    localparam logic [2:0] V3 = 3'b010;
    localparam logic [2:0] V4 = 3'b011;
    localparam logic [2:0] V5 = 3'b001;
    localparam logic [2:0] V6 = 3'b101;
    localparam logic [2:0] V7 = 3'b111;

    // Gate outputs are taken straight from the HIGH and LOW state bits
    typedef enum logic [3:0] {
        LEG_IDLE = 4'b0001,
        LEG_DEAD = 4'b0010,
        LEG_HIGH = 4'b0100,
        LEG_LOW  = 4'b1000
    } leg_state_t;

    // second=0 gives Vn for sector n, second=1 gives the next vector (wrapping 6 -> 1)
    function automatic logic [2:0] sector_vector(input logic [2:0] sector, input logic second);
        logic [2:0] n;
        n = second ? ((sector == 3'd6) ? 3'd1 : sector + 3'd1) : sector;
        case (n)
            3'd1:    sector_vector = V1;
            3'd2:    sector_vector = V2;
            3'd3:    sector_vector = V3;
            3'd4:    sector_vector = V4;
            3'd5:    sector_vector = V5;
            3'd6:    sector_vector = V6;
            default: sector_vector = V0;
        endcase
    endfunction

endpackage

// File: rtl/ac_motor_gate_driver_if.sv
// ac_motor_gate_driver_if: SVM strobes in, gate drives and status out
interface ac_motor_gate_driver_if;

    logic       ENABLE;
    logic [2:0] SECTOR_IN;
    logic       U_0;
    logic       U_1;
    logic       U_2;
    logic       U_7;
    logic       HS_A;
    logic       LS_A;
    logic       HS_B;
    logic       LS_B;
    logic       HS_C;
    logic       LS_C;
    logic [2:0] VECTOR_OUT;
    logic       FAULT;

    modport master (
        output ENABLE, SECTOR_IN, U_0, U_1, U_2, U_7,
        input  HS_A, LS_A, HS_B, LS_B, HS_C, LS_C, VECTOR_OUT, FAULT
    );

    modport slave (
        input  ENABLE, SECTOR_IN, U_0, U_1, U_2, U_7,
        output HS_A, LS_A, HS_B, LS_B, HS_C, LS_C, VECTOR_OUT, FAULT
    );

endinterface

// File: rtl/ac_motor_gate_driver_deadtime_leg.sv
// ac_motor_deadtime_leg: one inverter leg with break-before-make dead time
module ac_motor_deadtime_leg
    import ac_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 100,
    parameter int CNT_W       = 8
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic run,
    input  logic tgt,
    output logic hs,
    output logic ls
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEAD_CYCLES - 1);

    leg_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             lat, lat_nxt;

    // State, dead counter and latched target register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= LEG_IDLE;
            cnt   <= '0;
            lat   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            lat   <= lat_nxt;
        end
    end

    // Any target change re-enters or restarts DEAD, so dead time is never shortened
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        lat_nxt   = lat;
        if (!run) begin
            state_nxt = LEG_IDLE;
            cnt_nxt   = '0;
        end else begin
            case (state)
                LEG_IDLE: begin
                    state_nxt = LEG_DEAD;
                    cnt_nxt   = '0;
                    lat_nxt   = tgt;
                end
                LEG_DEAD: begin
                    if (tgt != lat) begin
                        cnt_nxt = '0;
                        lat_nxt = tgt;
                    end else if (cnt == CNT_LAST) begin
                        state_nxt = tgt ? LEG_HIGH : LEG_LOW;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
                LEG_HIGH, LEG_LOW: begin
                    if (tgt != (state == LEG_HIGH)) begin
                        state_nxt = LEG_DEAD;
                        cnt_nxt   = '0;
                        lat_nxt   = tgt;
                    end
                end
                default: state_nxt = LEG_IDLE;
            endcase
        end
    end

    assign hs = state[2];
    assign ls = state[3];

endmodule

// File: rtl/ac_motor_gate_driver.sv
// ac_motor_gate_driver: SVM vector to six dead-time protected gate drives
module ac_motor_gate_driver
    import ac_motor_pkg::*;
#(
    parameter int DEAD_CYCLES = 100,
    parameter int CNT_W       = 8
) (
    input logic                  CLK,
    input logic                  RST_N,
    ac_motor_gate_driver_if.slave bus
);

    logic [2:0] n_u;
    logic       bad;
    logic [2:0] mapped;
    logic [2:0] vec;
    logic       fault;
    logic       run;
    logic [2:0] hs;
    logic [2:0] ls;

    assign n_u    = 3'(bus.U_0) + 3'(bus.U_1) + 3'(bus.U_2) + 3'(bus.U_7);
    assign bad    = (n_u > 3'd1) ||
                    ((bus.U_1 || bus.U_2) && (bus.SECTOR_IN == 3'd0 || bus.SECTOR_IN == 3'd7));
    assign mapped = bus.U_0 ? V0 : bus.U_7 ? V7 : sector_vector(bus.SECTOR_IN, bus.U_2);
    assign run    = bus.ENABLE && !fault;

    // Target vector follows a single legal strobe; fault latches until ENABLE drops
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            vec   <= V0;
            fault <= 1'b0;
        end else begin
            vec   <= (n_u == 3'd1 && !bad) ? mapped : vec;
            fault <= bus.ENABLE && (fault || bad);
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_leg
        ac_motor_deadtime_leg #(
            .DEAD_CYCLES(DEAD_CYCLES),
            .CNT_W      (CNT_W)
        ) u_leg (
            .CLK  (CLK),
            .RST_N(RST_N),
            .run  (run),
            .tgt  (vec[i]),
            .hs   (hs[i]),
            .ls   (ls[i])
        );
    end

    assign bus.HS_A       = hs[2];
    assign bus.LS_A       = ls[2];
    assign bus.HS_B       = hs[1];
    assign bus.LS_B       = ls[1];
    assign bus.HS_C       = hs[0];
    assign bus.LS_C       = ls[0];
    assign bus.VECTOR_OUT = vec;
    assign bus.FAULT      = fault;

endmodule

// File: tb/tb_ac_motor_gate_driver.sv
// tb_ac_motor_gate_driver: directed plan plus random strobes against a streak-based model
module tb_ac_motor_gate_driver;

    localparam int D = 100;
    localparam logic [2:0] VT [0:7] = '{3'b000, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b000};

    logic CLK   = 1'b0;
    logic RST_N = 1'b1;
    logic chk_on = 1'b0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   overlap = 0;

    ac_motor_gate_driver_if bus ();

    ac_motor_gate_driver #(.DEAD_CYCLES(D), .CNT_W(8)) dut (
        .CLK  (CLK),
        .RST_N(RST_N),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    logic [5:0] gates;
    assign gates = {bus.HS_A, bus.LS_A, bus.HS_B, bus.LS_B, bus.HS_C, bus.LS_C};

    // Model: a leg conducts toward its target once run and target have been steady for more than D edges
    int         m_n;
    logic       m_bad;
    logic [2:0] m_map;
    logic [2:0] m_vec;
    logic       m_fault;
    int         streak [3];
    logic       ptgt [3];
    logic [5:0] exp_gates;

    always_comb begin
        m_n   = int'(bus.U_0) + int'(bus.U_1) + int'(bus.U_2) + int'(bus.U_7);
        m_bad = m_n > 1 || ((bus.U_1 || bus.U_2) && (bus.SECTOR_IN == 3'd0 || bus.SECTOR_IN == 3'd7));
        m_map = bus.U_0 ? 3'b000 : bus.U_7 ? 3'b111 :
                bus.U_1 ? VT[bus.SECTOR_IN] : VT[int'(bus.SECTOR_IN) % 6 + 1];
        for (int i = 0; i < 3; i++) begin
            exp_gates[5 - 2 * i] = streak[i] > D && ptgt[i];
            exp_gates[4 - 2 * i] = streak[i] > D && !ptgt[i];
        end
    end

    always @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            m_vec   <= 3'b000;
            m_fault <= 1'b0;
            for (int i = 0; i < 3; i++) begin
                streak[i] <= 0;
                ptgt[i]   <= 1'b0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                streak[i] <= !(bus.ENABLE && !m_fault) ? 0 :
                             (streak[i] > 0 && ptgt[i] == m_vec[2 - i]) ? streak[i] + 1 : 1;
                ptgt[i]   <= m_vec[2 - i];
            end
            if (m_n == 1 && !m_bad) m_vec <= m_map;
            m_fault <= bus.ENABLE && (m_fault || m_bad);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            check("cycle_gates", 32'(gates), 32'(exp_gates));
            check("cycle_vector", 32'(bus.VECTOR_OUT), 32'(m_vec));
            check("cycle_fault", 32'(bus.FAULT), 32'(m_fault));
        end
    end

    always @(negedge CLK) begin
        assert (!((bus.HS_A && bus.LS_A) || (bus.HS_B && bus.LS_B) || (bus.HS_C && bus.LS_C)))
        else overlap++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // u = {U_0, U_1, U_2, U_7}
    task automatic drive(input logic [3:0] u, input logic [2:0] s);
        {bus.U_0, bus.U_1, bus.U_2, bus.U_7} = u;
        bus.SECTOR_IN = s;
    endtask

    // Posedges from the current negedge until gates[b] reads v; -1 if it never does
    task automatic wait_gate(input int b, input logic v, output int n);
        n = 0;
        do begin
            @(posedge CLK);
            n++;
            @(negedge CLK);
        end while (gates[b] !== v && n < 1000);
        if (gates[b] !== v) n = -1;
    endtask

    int n, m, r, d, a;
    logic [3:0] u;
    logic [2:0] s;

    initial begin
        bus.ENABLE = 1'b0;
        drive(4'b0000, 3'd1);
        #1 RST_N = 1'b0;
        tick(3);
        RST_N  = 1'b1;
        chk_on = 1'b1;
        check("reset_gates", 32'(gates), 0);
        check("reset_vector", 32'(bus.VECTOR_OUT), 0);
        check("reset_fault", 32'(bus.FAULT), 0);

        // Enable with U_0: IDLE exit on the first edge, LS on D edges later
        bus.ENABLE = 1'b1;
        drive(4'b1000, 3'd1);
        wait_gate(4, 1'b1, n);
        check("enable_ls_a_delay", 32'(n), 32'(D + 1));
        check("enable_hs_off", 32'(gates & 6'b101010), 0);
        check("enable_ls_all", 32'(gates), 32'(6'b010101));
        tick(400);

        // Sector 1 walk
        drive(4'b0100, 3'd1);
        wait_gate(4, 1'b0, n);
        check("ls_a_fall_e2", 32'(n), 2);
        wait_gate(5, 1'b1, n);
        check("hs_a_rise_dead", 32'(n), 32'(D));
        tick(398);
        check("vec_100", 32'(bus.VECTOR_OUT), 32'(3'b100));
        check("bc_still_low", 32'(gates), 32'(6'b100101));
        drive(4'b0010, 3'd1);
        tick(500);
        check("vec_110", 32'(bus.VECTOR_OUT), 32'(3'b110));
        check("gates_110", 32'(gates), 32'(6'b101001));
        drive(4'b0001, 3'd1);
        tick(500);
        check("vec_111", 32'(bus.VECTOR_OUT), 32'(3'b111));
        check("gates_111", 32'(gates), 32'(6'b101010));

        // Sector wrap
        drive(4'b0010, 3'd6);
        tick(2);
        check("wrap_u2_v1", 32'(bus.VECTOR_OUT), 32'(3'b100));
        drive(4'b0100, 3'd6);
        tick(2);
        check("wrap_u1_v6", 32'(bus.VECTOR_OUT), 32'(3'b101));
        tick(300);
        check("a_high_pre", 32'(bus.HS_A), 1);

        // Dead-time restart: target returns at dead cycle 50
        drive(4'b1000, 3'd6);
        wait_gate(5, 1'b0, n);
        check("restart_fall", 32'(n), 2);
        tick(48);
        drive(4'b0100, 3'd6);
        wait_gate(5, 1'b1, m);
        check("restart_total", 32'(48 + m), 32'(D + 50));
        tick(200);

        // Faults
        drive(4'b0110, 3'd1);
        tick(1);
        check("fault_set_e1", 32'(bus.FAULT), 1);
        tick(1);
        check("fault_gates_e2", 32'(gates), 0);
        drive(4'b0100, 3'd2);
        tick(20);
        check("fault_persist", 32'(bus.FAULT), 1);
        check("fault_gates_off", 32'(gates), 0);
        bus.ENABLE = 1'b0;
        tick(1);
        check("fault_clear", 32'(bus.FAULT), 0);
        bus.ENABLE = 1'b1;
        drive(4'b0100, 3'd0);
        tick(1);
        check("fault_sector0_u1", 32'(bus.FAULT), 1);
        bus.ENABLE = 1'b0;
        tick(1);
        bus.ENABLE = 1'b1;
        drive(4'b1000, 3'd0);
        tick(2);
        check("sector0_u0_ok", 32'(bus.FAULT), 0);
        drive(4'b0100, 3'd1);
        tick(300);

        // Asynchronous reset mid-HIGH
        check("a_high_pre_rst", 32'(bus.HS_A), 1);
        #2 RST_N = 1'b0;
        #1 check("rst_async_high", 32'(gates), 0);
        check("rst_async_vec", 32'(bus.VECTOR_OUT), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_gate(2, 1'b1, n);
        check("rst_release_dead", 32'(n), 32'(D + 1));
        tick(150);

        // Asynchronous reset mid-DEAD on leg B
        drive(4'b0010, 3'd1);
        tick(20);
        #2 RST_N = 1'b0;
        #1 check("rst_async_dead", 32'(gates), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        wait_gate(3, 1'b1, n);
        check("rst_dead_hs_b", 32'(n), 32'(D + 2));

        // Random strobes
        for (int k = 0; k < 60; k++) begin
            r = $urandom_range(0, 19);
            d = $urandom_range(1, 250);
            a = $urandom_range(0, 3);
            s = 3'($urandom_range(1, 6));
            u = 4'b1000 >> a;
            if (r == 0) begin
                bus.ENABLE = 1'b0;
                tick(d % 4 + 1);
                bus.ENABLE = 1'b1;
            end else if (r < 3) drive(u | (4'b1000 >> ((a + $urandom_range(1, 3)) % 4)), s);
            else if (r == 3) drive(4'b0100 >> $urandom_range(0, 1), $urandom_range(0, 1) ? 3'd0 : 3'd7);
            else if (r == 4) drive(4'b0000, s);
            else drive(u, s);
            tick(d);
            if (r < 4 && $urandom_range(0, 1) == 1) begin
                bus.ENABLE = 1'b0;
                tick(1);
                bus.ENABLE = 1'b1;
            end
        end

        tick(5);
        check("no_overlap", 32'(overlap), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
